// File: rtl/paddle_axis_emu_if.sv
// Paddle emulator bundle: mouse packets and analog joystick in, selected paddle positions out.
interface paddle_axis_emu_if #(
  parameter int NUM_AXES = 2,
  parameter int AXW      = 8,
  parameter int DELTA_W  = 9
);
  logic                        mouse_stb;
  logic [NUM_AXES*DELTA_W-1:0] mouse_d;
  logic [NUM_AXES*AXW-1:0]     joya;
  logic                        wrap_en;
  logic [1:0]                  sens;
  logic                        recenter;
  logic [NUM_AXES*AXW-1:0]     axis_out;
  logic                        mouse_active;
  logic                        upd;
  logic                        busy;

  modport master (
    output mouse_stb, mouse_d, joya, wrap_en, sens, recenter,
    input  axis_out, mouse_active, upd, busy
  );

  modport slave (
    input  mouse_stb, mouse_d, joya, wrap_en, sens, recenter,
    output axis_out, mouse_active, upd, busy
  );
endinterface

// File: rtl/paddle_axis_emu.sv
// Integrates relative mouse deltas into signed paddle positions, one axis per cycle.
// Any nonzero analog joystick value takes control back and clears the positions.
module paddle_axis_emu #(
  parameter int NUM_AXES = 2,
  parameter int AXW      = 8,
  parameter int DELTA_W  = 9,
  parameter int MAX_STEP = 10
) (
  input logic            clk_sys,
  input logic            reset_n,
  paddle_axis_emu_if.slave bus
);
  localparam int IW   = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
  localparam int SW   = AXW + 3;
  localparam int PMAX = 2 ** (AXW - 1) - 1;
  localparam int PMIN = -(2 ** (AXW - 1));

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                      state, state_n;
  logic                        stb_q, pending, mouse_active, upd, busy;
  logic [IW-1:0]               idx;
  logic signed [AXW-1:0]       pos  [NUM_AXES];
  logic signed [DELTA_W-1:0]   dreg [NUM_AXES];
  logic [NUM_AXES*DELTA_W-1:0] pend_d;
  logic [NUM_AXES*AXW-1:0]     pos_flat;
  logic                        evt, analog;

  assign evt    = (bus.mouse_stb != stb_q);
  assign analog = |bus.joya;

  function automatic logic signed [AXW-1:0] next_pos(
    input logic signed [AXW-1:0]     p,
    input logic signed [DELTA_W-1:0] d,
    input logic [1:0]                s,
    input logic                      wrap
  );
    int                    dv, sv;
    logic signed [SW-1:0]  dc, sum;
    logic signed [AXW-1:0] res;
    dv = 32'(d);
    if (dv > MAX_STEP)       dv = MAX_STEP;
    else if (dv < -MAX_STEP) dv = -MAX_STEP;
    dc  = SW'(dv);
    sum = SW'(p) + (dc <<< s);
    sv  = 32'(sum);
    res = sum[AXW-1:0];
    if (!wrap) begin
      if (sv > PMAX)      res = AXW'(PMAX);
      else if (sv < PMIN) res = AXW'(PMIN);
    end
    return res;
  endfunction

  always_comb begin
    state_n = state;
    if (analog || bus.recenter) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (evt || pending) state_n = ACC;
        ACC:     if (idx == IW'(NUM_AXES - 1)) state_n = DONE;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      stb_q        <= 1'b0;
      pending      <= 1'b0;
      pend_d       <= '0;
      mouse_active <= 1'b0;
      upd          <= 1'b0;
      busy         <= 1'b0;
      idx          <= '0;
      for (int unsigned i = 0; i < NUM_AXES; i++) begin
        pos[i]  <= '0;
        dreg[i] <= '0;
      end
    end else begin
      stb_q <= bus.mouse_stb;
      upd   <= (state == DONE) && !analog && !bus.recenter;
      busy  <= (state_n != IDLE);
      if (analog) begin
        // joystick wins outright: a same-cycle mouse packet is dropped, not queued
        mouse_active <= 1'b0;
        pending      <= 1'b0;
        for (int unsigned i = 0; i < NUM_AXES; i++) pos[i] <= '0;
      end else if (bus.recenter) begin
        for (int unsigned i = 0; i < NUM_AXES; i++) pos[i] <= '0;
        if (evt) begin
          pending <= 1'b1;
          pend_d  <= bus.mouse_d;
        end
      end else if (state == IDLE) begin
        if (evt || pending) begin
          for (int unsigned i = 0; i < NUM_AXES; i++)
            dreg[i] <= evt ? bus.mouse_d[i*DELTA_W +: DELTA_W] : pend_d[i*DELTA_W +: DELTA_W];
          pending      <= 1'b0;
          mouse_active <= 1'b1;
          idx          <= '0;
        end
      end else begin
        if (evt) begin
          pending <= 1'b1;
          pend_d  <= bus.mouse_d;
        end
        if (state == ACC) begin
          pos[idx] <= next_pos(pos[idx], dreg[idx], bus.sens, bus.wrap_en);
          idx      <= idx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    pos_flat = '0;
    for (int unsigned i = 0; i < NUM_AXES; i++) pos_flat[i*AXW +: AXW] = pos[i];
  end

  assign bus.axis_out     = mouse_active ? pos_flat : bus.joya;
  assign bus.mouse_active = mouse_active;
  assign bus.upd          = upd;
  assign bus.busy         = busy;
endmodule

// File: tb/tb_paddle_axis_emu.sv
// Bench for paddle_axis_emu: scenario tasks checked against an arithmetic position model.
module tb_paddle_axis_emu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  paddle_axis_emu_if #(.NUM_AXES(2), .AXW(8), .DELTA_W(9)) bus();

  paddle_axis_emu #(.NUM_AXES(2), .AXW(8), .DELTA_W(9), .MAX_STEP(10)) dut (
    .clk_sys (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  int mp [2];

  function automatic int mstep(input int p, input int d, input int s, input bit w);
    int dc, sum;
    dc  = (d > 10) ? 10 : ((d < -10) ? -10 : d);
    sum = p + dc * (1 << s);
    if (!w) return (sum > 127) ? 127 : ((sum < -128) ? -128 : sum);
    sum = ((sum % 256) + 256) % 256;
    return (sum > 127) ? sum - 256 : sum;
  endfunction

  function automatic void model_apply(input int d0, input int d1);
    mp[0] = mstep(mp[0], d0, int'(bus.sens), bus.wrap_en);
    mp[1] = mstep(mp[1], d1, int'(bus.sens), bus.wrap_en);
  endfunction

  function automatic int ax(input int i);
    logic signed [7:0] b;
    b = bus.axis_out[i*8 +: 8];
    return int'(b);
  endfunction

  function automatic int rnd_delta();
    logic signed [8:0] r;
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 24)) - 12;
    r = 9'($urandom);
    return int'(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_event(input int d0, input int d1);
    bus.mouse_d   = {9'(d1), 9'(d0)};
    bus.mouse_stb = ~bus.mouse_stb;
  endtask

  task automatic wait_upd(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.upd) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.mouse_stb = 1'b0; bus.mouse_d = '0; bus.joya = 16'h1200;
    bus.wrap_en = 1'b0; bus.sens = 2'd0; bus.recenter = 1'b0;
    #3;
    checks++; if (bus.axis_out !== 16'h1200) begin failures++; $display("FAIL reset_axis_out: got %h want 1200", bus.axis_out); end
    checks++; if (bus.mouse_active !== 1'b0) begin failures++; $display("FAIL reset_active: got %b want 0", bus.mouse_active); end
    checks++; if (bus.upd !== 1'b0) begin failures++; $display("FAIL reset_upd: got %b want 0", bus.upd); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tick();
    rst_n = 1'b1;
    bus.joya = '0;
    mp[0] = 0; mp[1] = 0;
    tick();
  endtask

  task automatic test_basic();
    int pulses, first_k;
    bus.sens = 2'd0; bus.wrap_en = 1'b0;
    drive_event(5, -3);
    model_apply(5, -3);
    tick();
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b want 1", bus.busy); end
    tick();
    checks++; if (ax(0) !== mp[0] || ax(1) !== 0) begin failures++; $display("FAIL basic_axis0_latency: got %0d/%0d want %0d/0", ax(0), ax(1), mp[0]); end
    pulses = 0; first_k = -1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.upd) begin pulses++; if (first_k < 0) first_k = k; end
    end
    checks++; if (pulses !== 1 || first_k !== 1) begin failures++; $display("FAIL basic_upd: got pulses=%0d at %0d want 1 at 1", pulses, first_k); end
    checks++; if (ax(0) !== 5 || ax(1) !== -3) begin failures++; $display("FAIL basic_pos: got %0d/%0d want 5/-3", ax(0), ax(1)); end
    checks++; if (bus.mouse_active !== 1'b1) begin failures++; $display("FAIL basic_active: got %b want 1", bus.mouse_active); end
  endtask

  task automatic recenter_now();
    bus.recenter = 1'b1;
    tick();
    bus.recenter = 1'b0;
    mp[0] = 0; mp[1] = 0;
    checks++; if (bus.axis_out !== 16'h0000) begin failures++; $display("FAIL recenter_zero: got %h want 0000", bus.axis_out); end
  endtask

  task automatic test_sat_wrap();
    int exp_sat [4] = '{40, 80, 120, 127};
    int exp_wrp [4] = '{40, 80, 120, -96};
    bit seen;
    int d1;
    for (int w = 0; w < 2; w++) begin
      recenter_now();
      bus.sens = 2'd2; bus.wrap_en = (w == 1);
      for (int n = 0; n < 4; n++) begin
        d1 = rnd_delta();
        drive_event(100, d1);
        model_apply(100, d1);
        wait_upd(seen);
        checks++; if (!seen) begin failures++; $display("FAIL satwrap_timeout: got no upd want upd (w=%0d n=%0d)", w, n); end
        checks++; if (ax(0) !== ((w == 1) ? exp_wrp[n] : exp_sat[n])) begin failures++; $display("FAIL satwrap_axis0: got %0d want %0d (w=%0d n=%0d)", ax(0), (w == 1) ? exp_wrp[n] : exp_sat[n], w, n); end
        checks++; if (ax(1) !== mp[1]) begin failures++; $display("FAIL satwrap_axis1: got %0d want %0d", ax(1), mp[1]); end
      end
    end
    recenter_now();
    bus.sens = 2'd0; bus.wrap_en = 1'b0;
    drive_event(-100, 0);
    model_apply(-100, 0);
    wait_upd(seen);
    checks++; if (!seen || ax(0) !== -10) begin failures++; $display("FAIL neg_clamp: got %0d (upd=%b) want -10", ax(0), seen); end
  endtask

  task automatic test_random();
    bit seen;
    int d0, d1, gap;
    for (int n = 0; n < 40; n++) begin
      bus.sens = 2'($urandom_range(0, 3));
      bus.wrap_en = 1'($urandom_range(0, 1));
      d0 = rnd_delta(); d1 = rnd_delta();
      drive_event(d0, d1);
      model_apply(d0, d1);
      wait_upd(seen);
      checks++; if (!seen || ax(0) !== mp[0] || ax(1) !== mp[1]) begin failures++; $display("FAIL random_%0d: got %0d/%0d upd=%b want %0d/%0d", n, ax(0), ax(1), seen, mp[0], mp[1]); end
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic test_back_to_back();
    int pulses, extra, f0, f1, m1_0, m1_1;
    bit gap;
    bus.sens = 2'd1; bus.wrap_en = 1'b0;
    drive_event(7, -2);
    model_apply(7, -2);
    m1_0 = mp[0]; m1_1 = mp[1];
    tick();
    drive_event(-9, 4);
    tick();
    drive_event(3, 6);
    model_apply(3, 6);
    pulses = 0; extra = 0; gap = 1'b0; f0 = 0; f1 = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.upd) begin
        pulses++;
        if (pulses == 1) begin f0 = ax(0); f1 = ax(1); end
        else break;
      end else if (pulses == 1 && !bus.busy) gap = 1'b1;
    end
    for (int k = 0; k < 6; k++) begin tick(); if (bus.upd) extra++; end
    checks++; if (pulses !== 2 || extra !== 0) begin failures++; $display("FAIL b2b_pulses: got %0d+%0d want 2+0", pulses, extra); end
    checks++; if (f0 !== m1_0 || f1 !== m1_1) begin failures++; $display("FAIL b2b_first: got %0d/%0d want %0d/%0d", f0, f1, m1_0, m1_1); end
    checks++; if (ax(0) !== mp[0] || ax(1) !== mp[1]) begin failures++; $display("FAIL b2b_final: got %0d/%0d want %0d/%0d", ax(0), ax(1), mp[0], mp[1]); end
    checks++; if (gap !== 1'b0) begin failures++; $display("FAIL b2b_busy_gap: got gap=%b want 0", gap); end
  endtask

  task automatic test_analog();
    int pulses;
    bit seen;
    bus.joya = 16'h0001;
    drive_event(9, 9);
    tick();
    checks++; if (bus.mouse_active !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL analog_state: got active=%b busy=%b want 0/0", bus.mouse_active, bus.busy); end
    checks++; if (bus.axis_out !== 16'h0001) begin failures++; $display("FAIL analog_pass: got %h want 0001", bus.axis_out); end
    pulses = 0;
    for (int k = 0; k < 6; k++) begin tick(); if (bus.upd) pulses++; end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL analog_no_upd: got %0d want 0", pulses); end
    bus.joya = '0;
    tick();
    mp[0] = 0; mp[1] = 0;
    bus.sens = 2'd0; bus.wrap_en = 1'b0;
    drive_event(1, 2);
    model_apply(1, 2);
    wait_upd(seen);
    checks++; if (!seen || ax(0) !== 1 || ax(1) !== 2 || bus.mouse_active !== 1'b1) begin failures++; $display("FAIL analog_cleared: got %0d/%0d act=%b upd=%b want 1/2 act=1", ax(0), ax(1), bus.mouse_active, seen); end
  endtask

  task automatic test_recenter_pending();
    int pulses;
    bus.sens = 2'd0; bus.wrap_en = 1'b0;
    drive_event(4, 4);
    tick();
    drive_event(-6, 9);
    tick();
    bus.recenter = 1'b1;
    tick();
    bus.recenter = 1'b0;
    checks++; if (bus.axis_out !== 16'h0000 || bus.busy !== 1'b0 || bus.mouse_active !== 1'b1) begin failures++; $display("FAIL recenter_abort: got %h busy=%b act=%b want 0000 0 1", bus.axis_out, bus.busy, bus.mouse_active); end
    mp[0] = 0; mp[1] = 0;
    model_apply(-6, 9);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin tick(); if (bus.upd) pulses++; end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL recenter_upd: got %0d want 1", pulses); end
    checks++; if (ax(0) !== mp[0] || ax(1) !== mp[1]) begin failures++; $display("FAIL recenter_pending: got %0d/%0d want %0d/%0d", ax(0), ax(1), mp[0], mp[1]); end
  endtask

  task automatic test_reset_mid_acc();
    int pulses;
    bus.sens = 2'd0; bus.wrap_en = 1'b0;
    drive_event(8, -8);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.axis_out !== 16'h0000 || bus.mouse_active !== 1'b0) begin failures++; $display("FAIL async_reset_out: got %h act=%b want 0000 0", bus.axis_out, bus.mouse_active); end
    checks++; if (bus.busy !== 1'b0 || bus.upd !== 1'b0) begin failures++; $display("FAIL async_reset_flags: got busy=%b upd=%b want 0/0", bus.busy, bus.upd); end
    bus.mouse_stb = 1'b0;
    #3 rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin tick(); if (bus.upd || bus.busy) pulses++; end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL async_reset_quiet: got %0d active cycles want 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sat_wrap();
    test_random();
    test_back_to_back();
    test_analog();
    test_recenter_pending();
    test_reset_mid_acc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
